// File: rtl/bp_be_late_wb_arbiter.sv
// Late-writeback arbiter: one-entry buffer per long-latency requester, force-first
// round-robin grant, and a grant that stays frozen until the consumer accepts it.
module bp_be_late_wb_arbiter #(
  parameter int unsigned num_req_p      = 3,
  parameter int unsigned wb_pkt_width_p = 72
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p*wb_pkt_width_p-1:0]   req_pkt_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0]                  req_force_i,
  output logic [num_req_p-1:0]                  req_ready_and_o,
  output logic [wb_pkt_width_p-1:0]             late_wb_pkt_o,
  output logic                                  late_wb_v_o,
  output logic                                  late_wb_force_o,
  input  logic                                  late_wb_yumi_i,
  output logic                                  busy_o
);

  localparam int unsigned ptr_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [num_req_p-1:0]      full_r, force_r;
  logic [wb_pkt_width_p-1:0] pkt_r [num_req_p];
  logic [ptr_w-1:0]          rr_ptr_r;
  logic                      lock_r;
  logic [num_req_p-1:0]      lock_grant_r;

  logic [num_req_p-1:0]      eligible, arb_grant, grant, enq, deq;
  logic [ptr_w-1:0]          gnt_idx, next_ptr, srch_idx;
  logic                      found;
  int unsigned               srch_sum;

  // Forced buffers mask non-forced ones; first eligible index at or after rr_ptr wins.
  always_comb begin
    eligible  = (|(full_r & force_r)) ? (full_r & force_r) : full_r;
    arb_grant = '0;
    found     = 1'b0;
    srch_sum  = 0;
    srch_idx  = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      srch_sum = 32'(rr_ptr_r) + k;
      if (srch_sum >= num_req_p) srch_sum = srch_sum - num_req_p;
      srch_idx = ptr_w'(srch_sum);
      if (!found && eligible[srch_idx]) begin
        arb_grant[srch_idx] = 1'b1;
        found               = 1'b1;
      end
    end
  end

  assign grant       = lock_r ? lock_grant_r : arb_grant;
  assign late_wb_v_o = |grant;

  // One-hot grant makes an AND-OR mux sufficient; output is zero with no grant.
  always_comb begin
    late_wb_pkt_o   = '0;
    late_wb_force_o = 1'b0;
    gnt_idx         = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      late_wb_pkt_o   = late_wb_pkt_o | ({wb_pkt_width_p{grant[i]}} & pkt_r[i]);
      late_wb_force_o = late_wb_force_o | (grant[i] & force_r[i]);
      if (grant[i]) gnt_idx = ptr_w'(i);
    end
  end

  assign next_ptr        = (gnt_idx == ptr_w'(num_req_p - 1)) ? '0 : gnt_idx + ptr_w'(1);
  assign deq             = grant & {num_req_p{late_wb_yumi_i}};
  assign req_ready_and_o = ~full_r | deq;
  assign enq             = req_v_i & req_ready_and_o;
  assign busy_o          = (|full_r) | (|req_v_i);

  // Buffer fill/drain; a same-cycle refill wins over the drain.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_r  <= '0;
      force_r <= '0;
      for (int unsigned i = 0; i < num_req_p; i++) pkt_r[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (enq[i]) begin
          full_r[i]  <= 1'b1;
          force_r[i] <= req_force_i[i];
          pkt_r[i]   <= req_pkt_i[i*wb_pkt_width_p +: wb_pkt_width_p];
        end else if (deq[i]) begin
          full_r[i] <= 1'b0;
        end
      end
    end
  end

  // Grant freezes while presented without yumi; pointer advances past each accepted winner.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r     <= '0;
      lock_r       <= 1'b0;
      lock_grant_r <= '0;
    end else if (late_wb_v_o) begin
      if (late_wb_yumi_i) begin
        lock_r   <= 1'b0;
        rr_ptr_r <= next_ptr;
      end else begin
        lock_r       <= 1'b1;
        lock_grant_r <= grant;
      end
    end
  end

endmodule
